// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control types: the run/halt/step state encoding and the default stall timeout.
// No logic of its own.
// Imported by cpu_run_ctrl and stall_timer.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } run_state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    // Wide enough for any TIMEOUT up to 65535.
    localparam int STALL_CNT_W     = 16;

endpackage

// File: rtl/stall_timer.sv
// Counts consecutive data-memory stall cycles while the core is active; flags the cycle the count hits TIMEOUT.
// expire is combinational on the cycle of the TIMEOUT-th consecutive stall.
// No backpressure; the count clears on any non-stall cycle or while inactive.
module stall_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic stall,
    output logic expire
);

    logic [STALL_CNT_W-1:0] cnt;
    logic                   counting;

    assign counting = active & stall;
    // cnt holds the stalls already seen, so this cycle makes it TIMEOUT.
    assign expire   = counting & (cnt == STALL_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (counting) begin
            cnt <= cnt + STALL_CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller with a PC breakpoint, a memory-stall timeout and a retired-instruction counter.
// enable is combinational from state and inputs; flags, step_done and instr_count update one clock later.
// A memory stall, breakpoint hit or halt_req drops enable for that cycle; nothing is queued.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int RESET_RUN = 1,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic [31:0]      pc,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             enable,
    output logic             halted,
    output logic             step_done,
    output logic             bp_flag,
    output logic             to_err,
    output logic [CNT_W-1:0] instr_count
);

    run_state_t state;
    run_state_t state_nxt;
    logic       bp_skip;
    logic       stall;
    logic       bp_hit;
    logic       active;
    logic       expire;
    logic       resume;
    logic       set_bp;
    logic       set_to;

    assign stall  = mem_req & ~mem_ready;
    assign bp_hit = bp_en & (pc == bp_addr) & ~bp_skip;
    assign active = (state == RUN) | (state == STEP);
    assign enable = active & ~stall & ~bp_hit & ~halt_req & ~reset;
    assign halted = (state == HALT);

    stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk    (clk),
        .reset  (reset),
        .active (active),
        .stall  (stall),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        resume    = 1'b0;
        set_bp    = 1'b0;
        set_to    = 1'b0;
        case (state)
            HALT: begin
                if (!halt_req) begin
                    if (run_req) begin
                        state_nxt = RUN;
                        resume    = 1'b1;
                    end else if (step_req) begin
                        state_nxt = STEP;
                        resume    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else if (bp_hit) begin
                    state_nxt = HALT;
                    set_bp    = 1'b1;
                end else if (expire) begin
                    state_nxt = HALT;
                    set_to    = 1'b1;
                end
            end
            STEP: begin
                // enable already excludes halt_req, so a halted step never commits.
                if (halt_req || enable) begin
                    state_nxt = HALT;
                end else if (expire) begin
                    state_nxt = HALT;
                    set_to    = 1'b1;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (RESET_RUN != 0) ? RUN : HALT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_skip     <= 1'b0;
            step_done   <= 1'b0;
            bp_flag     <= 1'b0;
            to_err      <= 1'b0;
            instr_count <= '0;
        end else begin
            step_done <= (state == STEP) & enable;

            // Resuming skips the breakpoint once so the stopped instruction can retire.
            if (resume) begin
                bp_skip <= 1'b1;
            end else if (enable) begin
                bp_skip <= 1'b0;
            end

            if (resume) begin
                bp_flag <= 1'b0;
            end else if (set_bp) begin
                bp_flag <= 1'b1;
            end

            if (resume) begin
                to_err <= 1'b0;
            end else if (set_to) begin
                to_err <= 1'b1;
            end

            if (clr_cnt) begin
                instr_count <= '0;
            end else if (enable) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a behavioural model checked every cycle plus literal expectations.
// Main instance uses RESET_RUN=0, TIMEOUT=4, CNT_W=4; a default-parameter instance covers reset-to-RUN.
module tb_cpu_run_ctrl;

    localparam int TO      = 4;
    localparam int CNT_MOD = 16;

    logic        clk;
    logic        reset;
    logic        run_req;
    logic        halt_req;
    logic        step_req;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        mem_req;
    logic        mem_ready;
    logic        clr_cnt;

    logic        enable;
    logic        halted;
    logic        step_done;
    logic        bp_flag;
    logic        to_err;
    logic [3:0]  instr_count;

    logic        d_enable;
    logic        d_halted;
    logic        d_step_done;
    logic        d_bp_flag;
    logic        d_to_err;
    logic [31:0] d_instr_count;

    int checks;
    int failures;

    // Model state: which mode the controller is in and what it has accumulated.
    bit          m_run;
    bit          m_step;
    bit          m_skip;
    bit          m_bp;
    bit          m_to;
    bit          m_done;
    int          m_stall;
    int          m_cnt;

    int s_en, s_halted, s_done, s_bp, s_to, s_cnt;
    int s_def_en, s_def_halted, s_def_done, s_def_bp, s_def_to, s_def_cnt;

    cpu_run_ctrl #(
        .RESET_RUN (0),
        .TIMEOUT   (TO),
        .CNT_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .clr_cnt     (clr_cnt),
        .enable      (enable),
        .halted      (halted),
        .step_done   (step_done),
        .bp_flag     (bp_flag),
        .to_err      (to_err),
        .instr_count (instr_count)
    );

    cpu_run_ctrl dut_def (
        .clk         (clk),
        .reset       (reset),
        .run_req     (run_req),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .clr_cnt     (clr_cnt),
        .enable      (d_enable),
        .halted      (d_halted),
        .step_done   (d_step_done),
        .bp_flag     (d_bp_flag),
        .to_err      (d_to_err),
        .instr_count (d_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_step  = 1'b0;
        m_skip  = 1'b0;
        m_bp    = 1'b0;
        m_to    = 1'b0;
        m_done  = 1'b0;
        m_stall = 0;
        m_cnt   = 0;
    endtask

    function automatic bit model_hit();
        return bp_en && (pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit model_en();
        bit stalled;
        stalled = mem_req && !mem_ready;
        return !reset && (m_run || m_step) && !stalled && !model_hit() && !halt_req;
    endfunction

    task automatic model_advance();
        bit busy, hit, st, en;
        busy = m_run || m_step;
        hit  = model_hit();
        st   = mem_req && !mem_ready;
        en   = model_en();
        m_done = m_step && en;
        if (clr_cnt) m_cnt = 0;
        else if (en) m_cnt = (m_cnt + 1) % CNT_MOD;
        m_stall = (busy && st) ? m_stall + 1 : 0;
        if (!busy) begin
            if (!halt_req && (run_req || step_req)) begin
                m_run  = run_req;
                m_step = !run_req;
                m_skip = 1'b1;
                m_bp   = 1'b0;
                m_to   = 1'b0;
            end
        end else begin
            if (en) m_skip = 1'b0;
            if (halt_req || (m_step && en)) begin
                m_run = 1'b0; m_step = 1'b0;
            end else if (m_run && hit) begin
                m_run = 1'b0; m_step = 1'b0; m_bp = 1'b1;
            end else if (m_stall >= TO) begin
                m_run = 1'b0; m_step = 1'b0; m_to = 1'b1;
            end
        end
    endtask

    // One clock: sample and compare at the falling edge, then move inputs just after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_en         = int'(enable);
        s_halted     = int'(halted);
        s_done       = int'(step_done);
        s_bp         = int'(bp_flag);
        s_to         = int'(to_err);
        s_cnt        = int'(instr_count);
        s_def_en     = int'(d_enable);
        s_def_halted = int'(d_halted);
        s_def_done   = int'(d_step_done);
        s_def_bp     = int'(d_bp_flag);
        s_def_to     = int'(d_to_err);
        s_def_cnt    = int'(d_instr_count);
        if (reset) model_reset();
        chk("model_enable", s_en, int'(model_en()));
        chk("model_halted", s_halted, int'(!m_run && !m_step));
        chk("model_step_done", s_done, int'(m_done));
        chk("model_bp_flag", s_bp, int'(m_bp));
        chk("model_to_err", s_to, int'(m_to));
        chk("model_instr_count", s_cnt, m_cnt);
        if (!reset) model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        model_reset();
        reset = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        pc = 32'h0040_0000; bp_en = 1'b0; bp_addr = 32'h0040_0010;
        mem_req = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
        @(posedge clk); #1;

        tick();
        chk("rst_halted", s_halted, 1);
        chk("rst_enable", s_en, 0);
        chk("rst_cnt", s_cnt, 0);
        chk("rst_def_enable", s_def_en, 0);
        chk("rst_def_halted", s_def_halted, 0);
        chk("rst_def_flags", s_def_done + s_def_bp + s_def_to + s_def_cnt, 0);
        reset = 1'b0;
        tick();
        chk("def_run_enable", s_def_en, 1);

        // Single step from HALT.
        step_req = 1'b1; tick(); step_req = 1'b0;
        tick();
        chk("step_enable", s_en, 1);
        chk("step_not_halted", s_halted, 0);
        tick();
        chk("step_done", s_done, 1);
        chk("step_halted", s_halted, 1);
        chk("step_cnt", s_cnt, 1);
        chk("step_enable_off", s_en, 0);
        tick();
        chk("step_done_once", s_done, 0);

        // halt_req beats run_req in HALT; halt_req beats step_req in STEP.
        halt_req = 1'b1; run_req = 1'b1; tick(); halt_req = 1'b0; run_req = 1'b0;
        tick();
        chk("halt_over_run", s_halted, 1);
        step_req = 1'b1; tick(); step_req = 1'b0;
        halt_req = 1'b1; step_req = 1'b1; tick();
        chk("step_halt_enable", s_en, 0);
        halt_req = 1'b0; step_req = 1'b0;
        tick();
        chk("step_halt_halted", s_halted, 1);
        chk("step_halt_cnt", s_cnt, 1);
        chk("step_halt_done", s_done, 0);

        // Three-cycle memory stall in RUN.
        run_req = 1'b1; tick(); run_req = 1'b0;
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_enable", s_en, 0);
        end
        mem_ready = 1'b1; tick();
        chk("stall_release_enable", s_en, 1);
        chk("stall_to_err", s_to, 0);
        mem_req = 1'b0; mem_ready = 1'b0; halt_req = 1'b1; tick();
        chk("halt_cnt", s_cnt, 2);
        halt_req = 1'b0; tick();
        chk("halt_halted", s_halted, 1);

        // Timeout in RUN after TO stall cycles.
        run_req = 1'b1; tick(); run_req = 1'b0;
        mem_req = 1'b1;
        for (int i = 0; i < TO; i++) begin
            tick();
            chk("to_stall_enable", s_en, 0);
            chk("to_still_running", s_halted, 0);
        end
        tick();
        chk("to_halted", s_halted, 1);
        chk("to_err", s_to, 1);
        chk("to_cnt", s_cnt, 2);

        // Timeout in STEP.
        step_req = 1'b1; tick(); step_req = 1'b0;
        tick();
        chk("step_to_cleared", s_to, 0);
        for (int i = 1; i < TO; i++) tick();
        tick();
        chk("step_to_halted", s_halted, 1);
        chk("step_to_err", s_to, 1);
        chk("step_to_no_done", s_done, 0);
        mem_req = 1'b0;

        // Breakpoint at 0x0040_0010, PC advancing by 4 per commit.
        bp_en = 1'b1; run_req = 1'b1; tick(); run_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_run_enable", s_en, (i < 4) ? 1 : 0);
            if (s_en != 0) pc = pc + 32'd4;
        end
        tick();
        chk("bp_flag", s_bp, 1);
        chk("bp_halted", s_halted, 1);
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("bp_flag_held", s_bp, 1);
        tick();
        chk("bp_resume_enable", s_en, 1);
        chk("bp_flag_cleared", s_bp, 0);
        if (s_en != 0) pc = pc + 32'd4;
        tick();
        chk("bp_continue_enable", s_en, 1);
        if (s_en != 0) pc = pc + 32'd4;
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        tick();
        chk("bp_cnt", s_cnt, 8);
        bp_en = 1'b0;

        // Counter wrap after 16 commits, then clear during a commit.
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        tick();
        chk("clr_idle", s_cnt, 0);
        run_req = 1'b1; tick(); run_req = 1'b0;
        repeat (16) tick();
        halt_req = 1'b1; tick();
        chk("wrap_cnt", s_cnt, 0);
        halt_req = 1'b0; tick();
        run_req = 1'b1; tick(); run_req = 1'b0;
        tick();
        clr_cnt = 1'b1; tick();
        chk("clr_commit_enable", s_en, 1);
        clr_cnt = 1'b0; halt_req = 1'b1; tick();
        chk("clr_commit_cnt", s_cnt, 0);
        halt_req = 1'b0; tick();

        // Reset in the middle of a stalled step.
        step_req = 1'b1; tick(); step_req = 1'b0;
        mem_req = 1'b1; tick();
        reset = 1'b1; tick();
        reset = 1'b0; mem_req = 1'b0; tick();
        chk("mid_step_rst_halted", s_halted, 1);
        chk("mid_step_rst_done", s_done, 0);
        chk("mid_step_rst_cnt", s_cnt, 0);
        tick();
        chk("mid_step_rst_no_done", s_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
